// File: rtl/pwrdn_seq_pkg.sv
// Shared definitions for the master power-down sequencer: FSM encodings,
// stage indices, default timing constants and a mask helper.
package pwrdn_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'h0,
      ST_WAIT  = 4'h2,
      ST_GAP   = 4'h4,
      ST_DONE  = 4'h8,
      ST_FAULT = 4'hF
   } pwrdn_state_t;

   localparam logic [1:0] STG_NODE = 2'd2;
   localparam logic [1:0] STG_DEV  = 2'd1;
   localparam logic [1:0] STG_FAN  = 2'd0;

   localparam logic [15:0] DEF_DISCHG_TMO_MS = 16'd100;
   localparam logic [15:0] DEF_GAP_MS        = 16'd10;
   localparam logic [15:0] CNT_MAX           = 16'hFFFF;

   localparam logic [2:0] ALLOW_ALL = 3'b111;

   // Returns the allow mask with one stage removed.
   function automatic logic [2:0] clr_stage(input logic [2:0] mask, input logic [1:0] stg);
      logic [2:0] m;
      m      = mask;
      m[stg] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/pwrdn_tick_cnt.sv
// Saturating 16-bit millisecond counter shared by the discharge-wait and
// inter-stage gap phases; o_hit flags the tick that brings it to i_cmp.
module pwrdn_tick_cnt
   import pwrdn_seq_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic        i_tick,
   input  logic [15:0] i_cmp,
   output logic        o_hit
);

   logic [15:0] r_cnt;
   logic [15:0] w_cnt_inc;

   assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 16'd1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && i_tick) begin
         r_cnt <= w_cnt_inc;
      end
   end

   // Looks at the incremented value so the limit acts on the counted tick itself.
   assign o_hit = i_en & i_tick & (w_cnt_inc == i_cmp);

endmodule

// File: rtl/mstr_pwrdn_seq.sv
// Master power-down sequencer: drops node, device, then fan allows in turn,
// waiting for each power-good to fall. Build option PWRDN_FAULT_ALL_OFF_EN.
module mstr_pwrdn_seq
   import pwrdn_seq_pkg::*;
#(
   parameter logic [15:0] DISCHG_TMO_MS = DEF_DISCHG_TMO_MS,
   parameter logic [15:0] GAP_MS        = DEF_GAP_MS
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iTick_1ms,
   input  logic       iOff_Req,
   input  logic       iFull_Off_Req,
   input  logic [2:0] iPWRGD,
   output logic [2:0] oRail_Allow,
   output logic       oDone,
   output logic       oFault,
   output logic [1:0] oFault_Stage,
   output logic [3:0] oState
);

   pwrdn_state_t r_state;
   pwrdn_state_t w_state_next;
   logic [1:0]   r_cur;
   logic [1:0]   w_cur_next;
   logic [1:0]   r_tgt;
   logic [1:0]   w_tgt_next;
   logic [1:0]   r_fault_stg;
   logic [1:0]   w_fault_stg_next;
   logic [2:0]   r_allow;
   logic [2:0]   w_allow_next;
   logic         r_full_q;

   logic         w_full_rise;
   logic [1:0]   w_tgt_eff;
   logic [1:0]   w_cur_dec;
   logic         w_cnt_clr;
   logic         w_cnt_en;
   logic         w_cnt_hit;
   logic [15:0]  w_cnt_cmp;

   assign w_full_rise = iFull_Off_Req & ~r_full_q;
   // Escalation must count on the edge it arrives, even if that edge ends a stage.
   assign w_tgt_eff   = w_full_rise ? STG_FAN : r_tgt;
   assign w_cur_dec   = r_cur - 2'd1;
   assign w_cnt_en    = (r_state == ST_WAIT) || (r_state == ST_GAP);
   assign w_cnt_cmp   = (r_state == ST_GAP) ? GAP_MS : DISCHG_TMO_MS;

   pwrdn_tick_cnt u_tick_cnt (
      .i_clk  (iClk),
      .i_rst  (iRst),
      .i_clr  (w_cnt_clr),
      .i_en   (w_cnt_en),
      .i_tick (iTick_1ms),
      .i_cmp  (w_cnt_cmp),
      .o_hit  (w_cnt_hit)
   );

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_state     <= ST_IDLE;
         r_cur       <= STG_NODE;
         r_tgt       <= STG_DEV;
         r_fault_stg <= 2'd0;
         r_allow     <= ALLOW_ALL;
         r_full_q    <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cur       <= w_cur_next;
         r_tgt       <= w_tgt_next;
         r_fault_stg <= w_fault_stg_next;
         r_allow     <= w_allow_next;
         r_full_q    <= iFull_Off_Req;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_cur_next       = r_cur;
      w_tgt_next       = r_tgt;
      w_fault_stg_next = r_fault_stg;
      w_allow_next     = r_allow;
      w_cnt_clr        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (iOff_Req || iFull_Off_Req) begin
               w_cur_next   = STG_NODE;
               w_tgt_next   = iFull_Off_Req ? STG_FAN : STG_DEV;
               w_allow_next = clr_stage(r_allow, STG_NODE);
               w_cnt_clr    = 1'b1;
               w_state_next = ST_WAIT;
            end
         end

         ST_WAIT: begin
            w_tgt_next = w_tgt_eff;
            // A power-good fall outranks a coincident timeout tick.
            if (!iPWRGD[r_cur]) begin
               if (r_cur == w_tgt_eff) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_cnt_clr    = 1'b1;
                  w_state_next = ST_GAP;
               end
            end else if (w_cnt_hit) begin
               w_fault_stg_next = r_cur;
               w_state_next     = ST_FAULT;
`ifdef PWRDN_FAULT_ALL_OFF_EN
               w_allow_next     = 3'b000;
`endif
            end
         end

         ST_GAP: begin
            w_tgt_next = w_tgt_eff;
            if (w_cnt_hit) begin
               w_cur_next   = w_cur_dec;
               w_allow_next = clr_stage(r_allow, w_cur_dec);
               w_cnt_clr    = 1'b1;
               w_state_next = ST_WAIT;
            end
         end

         ST_DONE: begin
            if (!iOff_Req && !iFull_Off_Req) begin
               w_allow_next = ALLOW_ALL;
               w_state_next = ST_IDLE;
            end else if (iFull_Off_Req && (r_tgt == STG_DEV)) begin
               w_tgt_next   = STG_FAN;
               w_cur_next   = STG_FAN;
               w_allow_next = clr_stage(r_allow, STG_FAN);
               w_cnt_clr    = 1'b1;
               w_state_next = ST_WAIT;
            end
         end

         ST_FAULT: begin
            w_state_next = ST_FAULT;
         end

         default: begin
            w_allow_next = ALLOW_ALL;
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign oRail_Allow  = r_allow;
   assign oDone        = (r_state == ST_DONE);
   assign oFault       = (r_state == ST_FAULT);
   assign oFault_Stage = r_fault_stg;
   assign oState       = r_state;

endmodule

// File: tb/tb_mstr_pwrdn_seq.sv
// Scenario bench for mstr_pwrdn_seq: expected output snapshots are queued as
// stimulus is applied and compared after the clock edge that should produce them.
`timescale 1ns/1ps
module tb_mstr_pwrdn_seq;

   logic       iClk = 1'b0;
   logic       iRst;
   logic       iTick_1ms;
   logic       iOff_Req;
   logic       iFull_Off_Req;
   logic [2:0] iPWRGD;
   logic [2:0] oRail_Allow;
   logic       oDone;
   logic       oFault;
   logic [1:0] oFault_Stage;
   logic [3:0] oState;

   int checks = 0;
   int passes = 0;
   logic [10:0] sb_q[$];
   logic [10:0] exp_v;
   logic [10:0] obs_v;

`ifdef PWRDN_FAULT_ALL_OFF_EN
   localparam logic [2:0] FAULT_ALLOW = 3'b000;
`else
   localparam logic [2:0] FAULT_ALLOW = 3'b011;
`endif

   always #250 iClk = ~iClk;

   mstr_pwrdn_seq #(
      .DISCHG_TMO_MS (16'd100),
      .GAP_MS        (16'd10)
   ) dut (
      .iClk          (iClk),
      .iRst          (iRst),
      .iTick_1ms     (iTick_1ms),
      .iOff_Req      (iOff_Req),
      .iFull_Off_Req (iFull_Off_Req),
      .iPWRGD        (iPWRGD),
      .oRail_Allow   (oRail_Allow),
      .oDone         (oDone),
      .oFault        (oFault),
      .oFault_Stage  (oFault_Stage),
      .oState        (oState)
   );

   // {allow[2:0], done, fault, fault_stage[1:0], state[3:0]}
   function automatic logic [10:0] mk(input logic [2:0] a, input logic d, input logic f,
                                      input logic [1:0] s, input logic [3:0] st);
      return {a, d, f, s, st};
   endfunction

   function automatic logic [10:0] snap();
      return {oRail_Allow, oDone, oFault, oFault_Stage, oState};
   endfunction

   task automatic clk_cycle(input logic tick);
      iTick_1ms = tick;
      @(posedge iClk);
      #1;
      iTick_1ms = 1'b0;
   endtask

   // One millisecond: a tick cycle followed by two quiet cycles.
   task automatic ms(input int n);
      for (int k = 0; k < n; k++) begin
         clk_cycle(1'b1);
         clk_cycle(1'b0);
         clk_cycle(1'b0);
      end
   endtask

   task automatic test_reset();
      iRst = 1'b1; iTick_1ms = 1'b0; iOff_Req = 1'b0; iFull_Off_Req = 1'b0; iPWRGD = 3'b111;
      @(posedge iClk); #1;
      sb_q.push_back(mk(3'b111, 1'b0, 1'b0, 2'd0, 4'h0));
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL reset_val: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass reset_val %b", obs_v); end
      iRst = 1'b0;
      sb_q.push_back(mk(3'b111, 1'b0, 1'b0, 2'd0, 4'h0));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL reset_idle: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass reset_idle %b", obs_v); end
   endtask

   task automatic test_dc_off();
      iOff_Req = 1'b1;
      sb_q.push_back(mk(3'b011, 1'b0, 1'b0, 2'd0, 4'h2));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL dc_req: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass dc_req %b", obs_v); end

      sb_q.push_back(mk(3'b011, 1'b0, 1'b0, 2'd0, 4'h2));
      ms(5);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL dc_wait5: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass dc_wait5 %b", obs_v); end

      iPWRGD = 3'b011;
      sb_q.push_back(mk(3'b011, 1'b0, 1'b0, 2'd0, 4'h4));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL dc_gap: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass dc_gap %b", obs_v); end

      sb_q.push_back(mk(3'b011, 1'b0, 1'b0, 2'd0, 4'h4));
      ms(9);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL dc_gap9: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass dc_gap9 %b", obs_v); end

      sb_q.push_back(mk(3'b001, 1'b0, 1'b0, 2'd0, 4'h2));
      clk_cycle(1'b1);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL dc_gap10: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass dc_gap10 %b", obs_v); end

      ms(3);
      iPWRGD = 3'b001;
      sb_q.push_back(mk(3'b001, 1'b1, 1'b0, 2'd0, 4'h8));
      clk_cycle(1'b1);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL dc_done_fall_with_tick: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass dc_done_fall_with_tick %b", obs_v); end

      sb_q.push_back(mk(3'b001, 1'b1, 1'b0, 2'd0, 4'h8));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL dc_done_hold: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass dc_done_hold %b", obs_v); end
   endtask

   task automatic test_escalation_done();
      iFull_Off_Req = 1'b1;
      sb_q.push_back(mk(3'b000, 1'b0, 1'b0, 2'd0, 4'h2));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL esc_allow0: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass esc_allow0 %b", obs_v); end

      ms(2);
      iPWRGD = 3'b000;
      sb_q.push_back(mk(3'b000, 1'b1, 1'b0, 2'd0, 4'h8));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL esc_done: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass esc_done %b", obs_v); end
   endtask

   task automatic test_release();
      iOff_Req = 1'b0; iFull_Off_Req = 1'b0;
      sb_q.push_back(mk(3'b111, 1'b0, 1'b0, 2'd0, 4'h0));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL release: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass release %b", obs_v); end
      iPWRGD = 3'b111;
   endtask

   task automatic test_full_off();
      iOff_Req = 1'b1; iFull_Off_Req = 1'b1;
      sb_q.push_back(mk(3'b011, 1'b0, 1'b0, 2'd0, 4'h2));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL full_req: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass full_req %b", obs_v); end

      iPWRGD = 3'b011;
      sb_q.push_back(mk(3'b011, 1'b0, 1'b0, 2'd0, 4'h4));
      clk_cycle(1'b0);
      sb_q.push_back(mk(3'b001, 1'b0, 1'b0, 2'd0, 4'h2));
      ms(10);
      exp_v = sb_q.pop_front(); checks++;
      if (exp_v !== mk(3'b011, 1'b0, 1'b0, 2'd0, 4'h4)) $display("FAIL full_sb_order: got %b want gap", exp_v);
      else passes++;
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL full_rel_dev: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass full_rel_dev %b", obs_v); end

      iPWRGD = 3'b001;
      sb_q.push_back(mk(3'b001, 1'b0, 1'b0, 2'd0, 4'h4));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL full_gap_dev: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass full_gap_dev %b", obs_v); end

      sb_q.push_back(mk(3'b000, 1'b0, 1'b0, 2'd0, 4'h2));
      ms(10);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL full_rel_fan: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass full_rel_fan %b", obs_v); end

      iPWRGD = 3'b000;
      sb_q.push_back(mk(3'b000, 1'b1, 1'b0, 2'd0, 4'h8));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL full_done: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass full_done %b", obs_v); end

      test_release();
   endtask

   task automatic test_mid_seq();
      iOff_Req = 1'b1;
      clk_cycle(1'b0);
      iPWRGD = 3'b011;
      clk_cycle(1'b0);
      iOff_Req = 1'b0;
      sb_q.push_back(mk(3'b001, 1'b0, 1'b0, 2'd0, 4'h2));
      ms(10);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL mid_drop_ignored: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass mid_drop_ignored %b", obs_v); end

      iFull_Off_Req = 1'b1; iPWRGD = 3'b001;
      sb_q.push_back(mk(3'b001, 1'b0, 1'b0, 2'd0, 4'h4));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL mid_esc_same_edge: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass mid_esc_same_edge %b", obs_v); end

      sb_q.push_back(mk(3'b000, 1'b0, 1'b0, 2'd0, 4'h2));
      ms(10);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL mid_rel_fan: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass mid_rel_fan %b", obs_v); end

      iPWRGD = 3'b000;
      sb_q.push_back(mk(3'b000, 1'b1, 1'b0, 2'd0, 4'h8));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL mid_done: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass mid_done %b", obs_v); end

      test_release();
   endtask

   task automatic test_timeout();
      iOff_Req = 1'b1;
      clk_cycle(1'b1);  // tick on the WAIT-entry edge must not be counted
      sb_q.push_back(mk(3'b011, 1'b0, 1'b0, 2'd0, 4'h2));
      ms(99);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL tmo_99: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass tmo_99 %b", obs_v); end

      sb_q.push_back(mk(FAULT_ALLOW, 1'b0, 1'b1, 2'd2, 4'hF));
      clk_cycle(1'b1);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL tmo_fault: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass tmo_fault %b", obs_v); end

      iOff_Req = 1'b0; iPWRGD = 3'b000;
      sb_q.push_back(mk(FAULT_ALLOW, 1'b0, 1'b1, 2'd2, 4'hF));
      ms(2);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL tmo_sticky: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass tmo_sticky %b", obs_v); end

      #100 iRst = 1'b1;
      #10;
      sb_q.push_back(mk(3'b111, 1'b0, 1'b0, 2'd0, 4'h0));
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL tmo_rst_exit: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass tmo_rst_exit %b", obs_v); end
      @(posedge iClk); #1;
      iRst = 1'b0; iPWRGD = 3'b111;
   endtask

   task automatic test_reset_mid_wait();
      iOff_Req = 1'b1;
      clk_cycle(1'b0);
      sb_q.push_back(mk(3'b011, 1'b0, 1'b0, 2'd0, 4'h2));
      ms(3);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL rst_pre_wait: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass rst_pre_wait %b", obs_v); end

      #100 iRst = 1'b1;
      #5;
      sb_q.push_back(mk(3'b111, 1'b0, 1'b0, 2'd0, 4'h0));
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL rst_async: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass rst_async %b", obs_v); end

      iOff_Req = 1'b0;
      @(posedge iClk); #1;
      iRst = 1'b0;
      sb_q.push_back(mk(3'b111, 1'b0, 1'b0, 2'd0, 4'h0));
      clk_cycle(1'b0);
      exp_v = sb_q.pop_front(); obs_v = snap(); checks++;
      if (obs_v !== exp_v) $display("FAIL rst_idle_after: got %b want %b", obs_v, exp_v);
      else begin passes++; $display("pass rst_idle_after %b", obs_v); end
   endtask

   initial begin
      test_reset();
      test_dc_off();
      test_escalation_done();
      test_release();
      test_full_off();
      test_mid_seq();
      test_timeout();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d passes=%0d", checks, passes);
      $fatal(1, "watchdog");
   end

endmodule
